// File: rtl/box_render_pkg.sv
// Shared constants, palette ROM and darken helper for the box pixel renderer.
// The darken helper is only referenced when BOX_EDGE_EN is defined.
package box_render_pkg;

    localparam int RGB_W = 12;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

    // Constant 32-entry palette; entries 1-4 and 31 are the ones box_color relies on.
    function automatic logic [RGB_W-1:0] palette_lookup(input logic [IDX_W-1:0] idx);
        logic [RGB_W-1:0] rgb;
        case (idx)
            5'd0:    rgb = 12'h000;
            5'd1:    rgb = 12'hF00;
            5'd2:    rgb = 12'h0F0;
            5'd3:    rgb = 12'h00F;
            5'd4:    rgb = 12'hFF0;
            5'd5:    rgb = 12'h0FF;
            5'd6:    rgb = 12'hF0F;
            5'd7:    rgb = 12'h888;
            5'd31:   rgb = 12'hFFF;
            default: rgb = {idx[3:0], idx[4:1], ~idx[3:0]};
        endcase
        return rgb;
    endfunction

    function automatic logic [RGB_W-1:0] darken(input logic [RGB_W-1:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/box_hit_test.sv
// Combinational rectangle test with visible-area clip.
// Optional feature macro: BOX_EDGE_EN adds the 1-pixel border flag.
module box_hit_test #(
    parameter int H_BITS   = 10,
    parameter int V_BITS   = 10,
    parameter int BOX_W    = 64,
    parameter int BOX_H    = 32,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic [H_BITS-1:0] i_x,
    input  logic [V_BITS-1:0] i_y,
    input  logic [H_BITS-1:0] i_bx,
    input  logic [V_BITS-1:0] i_by,
`ifdef BOX_EDGE_EN
    output logic              o_edge,
`endif
    output logic              o_hit
);

    // One extra bit so bx+BOX_W can never wrap back into the visible range.
    localparam logic [H_BITS:0] LP_W     = (H_BITS+1)'(BOX_W);
    localparam logic [V_BITS:0] LP_H     = (V_BITS+1)'(BOX_H);
    localparam logic [H_BITS:0] LP_H_ACT = (H_BITS+1)'(H_ACTIVE);
    localparam logic [V_BITS:0] LP_V_ACT = (V_BITS+1)'(V_ACTIVE);

    logic [H_BITS:0] w_x, w_bx, w_bx_end;
    logic [V_BITS:0] w_y, w_by, w_by_end;

    assign w_x      = {1'b0, i_x};
    assign w_y      = {1'b0, i_y};
    assign w_bx     = {1'b0, i_bx};
    assign w_by     = {1'b0, i_by};
    assign w_bx_end = w_bx + LP_W;
    assign w_by_end = w_by + LP_H;

    assign o_hit = (w_x >= w_bx) && (w_x < w_bx_end) &&
                   (w_y >= w_by) && (w_y < w_by_end) &&
                   (w_x < LP_H_ACT) && (w_y < LP_V_ACT);

`ifdef BOX_EDGE_EN
    localparam logic [H_BITS:0] LP_W_M1 = (H_BITS+1)'(BOX_W - 1);
    localparam logic [V_BITS:0] LP_H_M1 = (V_BITS+1)'(BOX_H - 1);

    assign o_edge = (w_x == w_bx) || (w_x == w_bx + LP_W_M1) ||
                    (w_y == w_by) || (w_y == w_by + LP_H_M1);
`endif

endmodule

// File: rtl/box_pixel_render.sv
// Two-stage box renderer: frame-synchronous shadows, hit test, registered palette lookup.
// Optional feature macro: BOX_EDGE_EN darkens the 1-pixel border of drawn boxes.
module box_pixel_render
    import box_render_pkg::*;
#(
    parameter int H_BITS   = 10,
    parameter int V_BITS   = 10,
    parameter int BOX_W    = 64,
    parameter int BOX_H    = 32,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic              clk_machine,
    input  logic              rst_machine,
    input  logic              i_frame_start,
    input  logic              i_pix_valid,
    input  logic [H_BITS-1:0] i_pix_x,
    input  logic [V_BITS-1:0] i_pix_y,
    input  logic [IDX_W-1:0]  i_color_index1,
    input  logic [IDX_W-1:0]  i_color_index2,
    input  logic [H_BITS-1:0] i_box1_x,
    input  logic [V_BITS-1:0] i_box1_y,
    input  logic [H_BITS-1:0] i_box2_x,
    input  logic [V_BITS-1:0] i_box2_y,
    input  logic [RGB_W-1:0]  i_bg_rgb,
    output logic              o_pix_valid,
    output logic [RGB_W-1:0]  o_rgb,
    output logic [1:0]        o_hit
);

    logic [IDX_W-1:0]  r_idx [2];
    logic [H_BITS-1:0] r_bx  [2];
    logic [V_BITS-1:0] r_by  [2];

    logic             r_s1_valid;
    logic [1:0]       r_s1_hit;
    logic [IDX_W-1:0] r_s1_idx;
    logic [RGB_W-1:0] r_s1_bg;

    logic             r_pix_valid;
    logic [RGB_W-1:0] r_rgb;
    logic [1:0]       r_hit;

    logic [1:0]       w_hit;
    logic [1:0]       w_draw;
    logic [IDX_W-1:0] w_sel_idx;
    logic [RGB_W-1:0] w_box_rgb;

`ifdef BOX_EDGE_EN
    logic [1:0]       w_edge;
    logic             w_sel_edge;
    logic             r_s1_edge;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_box
            box_hit_test #(
                .H_BITS   (H_BITS),
                .V_BITS   (V_BITS),
                .BOX_W    (BOX_W),
                .BOX_H    (BOX_H),
                .H_ACTIVE (H_ACTIVE),
                .V_ACTIVE (V_ACTIVE)
            ) u_hit (
                .i_x    (i_pix_x),
                .i_y    (i_pix_y),
                .i_bx   (r_bx[gi]),
                .i_by   (r_by[gi]),
`ifdef BOX_EDGE_EN
                .o_edge (w_edge[gi]),
`endif
                .o_hit  (w_hit[gi])
            );
        end
    endgenerate

    // Transparent index suppresses a box; box1 wins when both are drawn.
    assign w_draw[0] = w_hit[0] && (r_idx[0] != TRANSPARENT_IDX);
    assign w_draw[1] = w_hit[1] && (r_idx[1] != TRANSPARENT_IDX) && !w_draw[0];
    assign w_sel_idx = w_draw[0] ? r_idx[0] : r_idx[1];

`ifdef BOX_EDGE_EN
    assign w_sel_edge = w_draw[0] ? w_edge[0] : w_edge[1];
    assign w_box_rgb  = r_s1_edge ? darken(palette_lookup(r_s1_idx)) : palette_lookup(r_s1_idx);
`else
    assign w_box_rgb  = palette_lookup(r_s1_idx);
`endif

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            for (int i = 0; i < 2; i++) begin
                r_idx[i] <= '0;
                r_bx[i]  <= '0;
                r_by[i]  <= '0;
            end
            r_s1_valid  <= 1'b0;
            r_s1_hit    <= 2'b00;
            r_s1_idx    <= '0;
            r_s1_bg     <= '0;
`ifdef BOX_EDGE_EN
            r_s1_edge   <= 1'b0;
`endif
            r_pix_valid <= 1'b0;
            r_rgb       <= '0;
            r_hit       <= 2'b00;
        end else begin
            if (i_frame_start) begin
                r_idx[0] <= i_color_index1;
                r_idx[1] <= i_color_index2;
                r_bx[0]  <= i_box1_x;
                r_by[0]  <= i_box1_y;
                r_bx[1]  <= i_box2_x;
                r_by[1]  <= i_box2_y;
            end

            r_s1_valid <= i_pix_valid;
            r_s1_hit   <= i_pix_valid ? w_draw : 2'b00;
            r_s1_idx   <= w_sel_idx;
            r_s1_bg    <= i_bg_rgb;
`ifdef BOX_EDGE_EN
            r_s1_edge  <= w_sel_edge;
`endif

            r_pix_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb <= (r_s1_hit != 2'b00) ? w_box_rgb : r_s1_bg;
                r_hit <= r_s1_hit;
            end else begin
                r_rgb <= '0;
                r_hit <= 2'b00;
            end
        end
    end

    assign o_pix_valid = r_pix_valid;
    assign o_rgb       = r_rgb;
    assign o_hit       = r_hit;

endmodule

// File: tb/tb_box_pixel_render.sv
// Self-checking bench for box_pixel_render: directed tables, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_box_pixel_render;

    localparam int BW = 64;
    localparam int BH = 32;
    localparam int HA = 640;
    localparam int VA = 480;

    localparam logic [11:0] E_F00 =
`ifdef BOX_EDGE_EN
        12'h700;
`else
        12'hF00;
`endif
    localparam logic [11:0] E_0F0 =
`ifdef BOX_EDGE_EN
        12'h070;
`else
        12'h0F0;
`endif

    logic       clk_machine = 1'b0;
    logic       rst_machine = 1'b1;
    logic       i_frame_start = 1'b0;
    logic       i_pix_valid = 1'b0;
    logic [9:0] i_pix_x = '0, i_pix_y = '0;
    logic [4:0] i_color_index1 = '0, i_color_index2 = '0;
    logic [9:0] i_box1_x = '0, i_box1_y = '0, i_box2_x = '0, i_box2_y = '0;
    logic [11:0] i_bg_rgb = '0;
    logic        o_pix_valid;
    logic [11:0] o_rgb;
    logic [1:0]  o_hit;

    box_pixel_render dut (
        .clk_machine    (clk_machine),
        .rst_machine    (rst_machine),
        .i_frame_start  (i_frame_start),
        .i_pix_valid    (i_pix_valid),
        .i_pix_x        (i_pix_x),
        .i_pix_y        (i_pix_y),
        .i_color_index1 (i_color_index1),
        .i_color_index2 (i_color_index2),
        .i_box1_x       (i_box1_x),
        .i_box1_y       (i_box1_y),
        .i_box2_x       (i_box2_x),
        .i_box2_y       (i_box2_y),
        .i_bg_rgb       (i_bg_rgb),
        .o_pix_valid    (o_pix_valid),
        .o_rgb          (o_rgb),
        .o_hit          (o_hit)
    );

    always #5 clk_machine = ~clk_machine;

    typedef struct packed {
        logic        v;
        logic [11:0] rgb;
        logic [1:0]  hit;
    } exp_t;

    typedef struct {
        string       name;
        int          x;
        int          y;
        logic [11:0] rgb;
        logic [1:0]  hit;
    } vec_t;

    // Model state: what the frame-latched box description is believed to be.
    int   m_idx1 = 0, m_idx2 = 0, m_b1x = 0, m_b1y = 0, m_b2x = 0, m_b2y = 0;
    exp_t p1 = '0, p2 = '0;
    int   n_checks = 0, n_pass = 0;
    string cur_name = "init";

    function automatic int pal(int idx);
        case (idx)
            1:       return 'hF00;
            2:       return 'h0F0;
            3:       return 'h00F;
            4:       return 'hFF0;
            31:      return 'hFFF;
            default: return 0;
        endcase
    endfunction

    function automatic int dark(int c);
        return ((((c >> 8) & 15) >> 1) << 8) | ((((c >> 4) & 15) >> 1) << 4) | ((c & 15) >> 1);
    endfunction

    function automatic bit in_box(int x, int y, int bx, int by);
        return x >= bx && x < bx + BW && y >= by && y < by + BH && x < HA && y < VA;
    endfunction

    function automatic bit on_border(int x, int y, int bx, int by);
        return x == bx || x == bx + BW - 1 || y == by || y == by + BH - 1;
    endfunction

    function automatic exp_t model(bit v, int x, int y, int bg);
        exp_t e;
        int   c;
        bit   brd;
        e = '0;
        if (!v) return e;
        e.v = 1'b1;
        brd = 1'b0;
        if (m_idx1 != 0 && in_box(x, y, m_b1x, m_b1y)) begin
            e.hit = 2'b01;
            c     = pal(m_idx1);
            brd   = on_border(x, y, m_b1x, m_b1y);
        end else if (m_idx2 != 0 && in_box(x, y, m_b2x, m_b2y)) begin
            e.hit = 2'b10;
            c     = pal(m_idx2);
            brd   = on_border(x, y, m_b2x, m_b2y);
        end else begin
            c = bg;
        end
`ifdef BOX_EDGE_EN
        if (brd) c = dark(c);
`else
        if (brd) c = c + 0;
`endif
        e.rgb = c[11:0];
        return e;
    endfunction

    task automatic check(string name, exp_t act, exp_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got v=%0b rgb=%03h hit=%02b, expected v=%0b rgb=%03h hit=%02b",
                      name, act.v, act.rgb, act.hit, exp.v, exp.rgb, exp.hit);
    endtask

    // Advance one clock; the model predicts the pixel on the inputs now and
    // the output is compared with the prediction made two cycles earlier.
    task automatic tick();
        exp_t e;
        e = '0;
        if (rst_machine) begin
            m_idx1 = 0; m_idx2 = 0; m_b1x = 0; m_b1y = 0; m_b2x = 0; m_b2y = 0;
        end else begin
            e = model(i_pix_valid, int'(i_pix_x), int'(i_pix_y), int'(i_bg_rgb));
            if (i_frame_start) begin
                m_idx1 = i_color_index1; m_idx2 = i_color_index2;
                m_b1x = i_box1_x; m_b1y = i_box1_y; m_b2x = i_box2_x; m_b2y = i_box2_y;
            end
        end
        @(posedge clk_machine);
        #1;
        if (rst_machine) begin
            p1 = '0;
            p2 = '0;
        end else begin
            p2 = p1;
            p1 = e;
        end
        check({cur_name, "/model"}, {o_pix_valid, o_rgb, o_hit}, p2);
    endtask

    task automatic frame(int i1, int i2, int b1x, int b1y, int b2x, int b2y, int bg);
        i_color_index1 = i1[4:0]; i_color_index2 = i2[4:0];
        i_box1_x = b1x[9:0]; i_box1_y = b1y[9:0];
        i_box2_x = b2x[9:0]; i_box2_y = b2y[9:0];
        i_bg_rgb = bg[11:0];
        i_frame_start = 1'b1;
        i_pix_valid   = 1'b0;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic pix_check(string name, int x, int y, logic [11:0] rgb, logic [1:0] hit);
        cur_name    = name;
        i_pix_x     = x[9:0];
        i_pix_y     = y[9:0];
        i_pix_valid = 1'b1;
        tick();
        i_pix_valid = 1'b0;
        tick();
        check(name, {o_pix_valid, o_rgb, o_hit}, {1'b1, rgb, hit});
    endtask

    int   idx_set [6] = '{0, 1, 2, 3, 4, 31};
    vec_t vecs [7];

    initial begin
        vecs[0] = '{"basic_tl",     100, 100, E_F00,   2'b01};
        vecs[1] = '{"basic_br",     163, 131, E_F00,   2'b01};
        vecs[2] = '{"basic_right",  164, 131, 12'h333, 2'b00};
        vecs[3] = '{"basic_box2",   300, 200, E_0F0,   2'b10};
        vecs[4] = '{"basic_inside", 110, 110, 12'hF00, 2'b01};
        vecs[5] = '{"basic_left",    99, 110, 12'h333, 2'b00};
        vecs[6] = '{"basic_below",  110, 132, 12'h333, 2'b00};

        // Reset held with valid pixels: outputs must stay cleared.
        cur_name    = "reset";
        rst_machine = 1'b1;
        i_pix_valid = 1'b1;
        i_pix_x = 10'd5; i_pix_y = 10'd5; i_bg_rgb = 12'hABC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", {o_pix_valid, o_rgb, o_hit}, '0);
        end
        rst_machine = 1'b0;
        i_pix_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_after", {o_pix_valid, o_rgb, o_hit}, '0);
        end

        cur_name = "basic";
        frame(1, 2, 100, 100, 300, 200, 'h333);
        for (int i = 0; i < 7; i++) pix_check(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].hit);

        cur_name = "overlap";
        frame(3, 4, 50, 50, 50, 50, 'h333);
        pix_check("overlap_prio", 60, 60, 12'h00F, 2'b01);
        frame(0, 4, 50, 50, 50, 50, 'h333);
        pix_check("overlap_transp", 60, 60, 12'hFF0, 2'b10);

        // Index change without frame_start must not tear the frame.
        cur_name = "tear";
        frame(1, 2, 100, 100, 300, 200, 'h000);
        pix_check("tear_before", 110, 110, 12'hF00, 2'b01);
        i_color_index1 = 5'd2;
        pix_check("tear_midframe", 110, 110, 12'hF00, 2'b01);
        i_frame_start = 1'b1;
        i_pix_valid   = 1'b1;
        tick();
        i_frame_start = 1'b0;
        tick();
        check("tear_fs_cycle", {o_pix_valid, o_rgb, o_hit}, {1'b1, 12'hF00, 2'b01});
        i_pix_valid = 1'b0;
        tick();
        check("tear_after_fs", {o_pix_valid, o_rgb, o_hit}, {1'b1, 12'h0F0, 2'b01});

        cur_name = "clip";
        frame(1, 0, 1020, 100, 0, 0, 'h555);
        pix_check("clip_nowrap", 2, 110, 12'h555, 2'b00);
        pix_check("clip_offscr", 1021, 110, 12'h555, 2'b00);
        frame(1, 0, 600, 470, 0, 0, 'h555);
        pix_check("clip_x639", 639, 475, 12'hF00, 2'b01);
        pix_check("clip_x640", 640, 475, 12'h555, 2'b00);
        pix_check("clip_y479", 610, 479, 12'hF00, 2'b01);
        pix_check("clip_y480", 610, 480, 12'h555, 2'b00);

        cur_name = "edge";
        frame(1, 0, 100, 100, 0, 0, 'h000);
        pix_check("edge_left", 100, 110, E_F00, 2'b01);
        pix_check("edge_inner", 110, 110, 12'hF00, 2'b01);

        // Reset in the middle of a pixel stream drops in-flight pixels.
        cur_name    = "midreset";
        i_pix_valid = 1'b1;
        i_pix_x = 10'd110; i_pix_y = 10'd110;
        tick();
        tick();
        rst_machine = 1'b1;
        tick();
        check("midreset_drop", {o_pix_valid, o_rgb, o_hit}, '0);
        rst_machine = 1'b0;
        i_pix_valid = 1'b0;
        tick();
        check("midreset_flush", {o_pix_valid, o_rgb, o_hit}, '0);
        tick();

        cur_name = "random";
        for (int n = 0; n < 3000; n++) begin
            rst_machine    = ($urandom_range(0, 399) == 0);
            i_frame_start  = ($urandom_range(0, 15) == 0);
            i_color_index1 = idx_set[$urandom_range(0, 5)][4:0];
            i_color_index2 = idx_set[$urandom_range(0, 5)][4:0];
            i_box1_x = 10'($urandom); i_box1_y = 10'($urandom);
            i_box2_x = 10'($urandom); i_box2_y = 10'($urandom);
            i_bg_rgb    = 12'($urandom);
            i_pix_valid = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 2))
                0: begin
                    i_pix_x = 10'(m_b1x + $urandom_range(0, 67) - 2);
                    i_pix_y = 10'(m_b1y + $urandom_range(0, 35) - 2);
                end
                1: begin
                    i_pix_x = 10'(m_b2x + $urandom_range(0, 67) - 2);
                    i_pix_y = 10'(m_b2y + $urandom_range(0, 35) - 2);
                end
                default: begin
                    i_pix_x = 10'($urandom);
                    i_pix_y = 10'($urandom);
                end
            endcase
            tick();
        end
        rst_machine   = 1'b0;
        i_frame_start = 1'b0;
        i_pix_valid   = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/box_pixel_render.md
Name: box_pixel_render

Overview:
- Downstream of box_color: converts the two 5-bit box colour indices into 12-bit RGB pixels for the VGA scan-out path.
- Per pixel, tests the scan coordinate against two box rectangles and selects a box colour or the background.
- Palette lookup is registered.
- Box colour indices and positions are captured once per frame so mid-frame changes never tear.

Parameters:
- H_BITS, 10, width of pixel x coordinate and box x position
- V_BITS, 10, width of pixel y coordinate and box y position
- BOX_W, 64, box width in pixels (must be >= 3)
- BOX_H, 32, box height in pixels (must be >= 3)
- H_ACTIVE, 640, visible width; box pixels at x >= H_ACTIVE are never drawn
- V_ACTIVE, 480, visible height; box pixels at y >= V_ACTIVE are never drawn

Ports:
- clk_machine  in  1  pixel/system clock (25 MHz)
- rst_machine  in  1  synchronous reset, active-high
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- i_pix_valid  in  1  current i_pix_x/i_pix_y is an active pixel
- i_pix_x  in  H_BITS  scan x
- i_pix_y  in  V_BITS  scan y
- i_color_index1  in  5  box 1 (current platform) colour index, from box_color
- i_color_index2  in  5  box 2 (target platform) colour index, from box_color
- i_box1_x  in  H_BITS  box 1 left edge
- i_box1_y  in  V_BITS  box 1 top edge
- i_box2_x  in  H_BITS  box 2 left edge
- i_box2_y  in  V_BITS  box 2 top edge
- i_bg_rgb  in  12  background colour, sampled in stage 1
- o_pix_valid  out  1  i_pix_valid delayed 2 cycles
- o_rgb  out  12  {R[3:0],G[3:0],B[3:0]}; 0 when o_pix_valid=0
- o_hit  out  2  bit0 = box1 drawn, bit1 = box2 drawn, aligned with o_rgb

Behaviour:
- Reset (synchronous, rst_machine=1 at a clock edge):
  - o_pix_valid=0, o_rgb=12'h000, o_hit=2'b00.
  - All shadow registers = 0.
  - Pipeline valids cleared.
  - Reset mid-frame discards in-flight pixels.
- Shadow capture:
  - On a cycle with i_frame_start=1, all six box inputs (two indices, four positions) load into shadow registers.
  - New values apply to pixels presented on the following cycle onward.
  - A pixel arriving in the same cycle as i_frame_start uses the old shadows.
- Stage 1 (registered), using shadow values:
  - Hit test: hitN = (x >= bx) && (x < bx+BOX_W) && (y >= by) && (y < by+BOX_H).
  - Computed in H_BITS+1 / V_BITS+1 bits so bx+BOX_W never wraps.
  - Additionally gated by x < H_ACTIVE and y < V_ACTIVE.
  - Colour index 0 means transparent: forces that box's hit to 0.
  - Priority: box1 over box2 when both hit. Selected index and i_bg_rgb are registered.
- Stage 2 (registered):
  - Palette ROM lookup (32 x 12, constant) of the selected index, or i_bg_rgb if no hit.
  - o_hit reports only the drawn box (never 2'b11).
- Latency: exactly 2 cycles from i_pix_valid to o_pix_valid. Full throughput, no stalls, no backpressure.
- Invalid pixels: i_pix_valid=0 propagates as o_pix_valid=0 with o_rgb=0 and o_hit=0. Shadow capture still occurs.

Optional Feature:
- BOX_EDGE_EN defined:
  - Pixels on the 1-pixel border of a drawn box output the palette colour with each 4-bit channel shifted right by 1 (e.g. F00 -> 700).
  - Edge flag is computed in stage 1. Latency is unchanged.
- BOX_EDGE_EN undefined: boxes are solid fill; no edge logic is synthesised.

Decomposition:
- Package box_render_pkg holds:
  - RGB width constant (12) and colour-index width (5).
  - TRANSPARENT_IDX = 0.
  - Palette constant/function. Fixed entries: 1=12'hF00, 2=12'h0F0, 3=12'h00F, 4=12'hFF0, 31=12'hFFF.
  - The darken function.
- One sub-module, box_hit_test:
  - Combinational rectangle test with clip.
  - Instantiated twice, once per box.

Test Plan:
- Reset: assert rst_machine 3 cycles while i_pix_valid=1 -> o_pix_valid=0, o_rgb=000, o_hit=00 throughout and 2 cycles after release until new pixels arrive.
- Basic draw:
  - Setup: frame_start with idx1=1, box1=(100,100), idx2=2, box2=(300,200), bg=12'h333.
  - Pixel (100,100) -> 2 cycles later F00, hit=01.
  - Pixel (163,131) -> F00.
  - Pixel (164,131) -> 333, hit=00.
  - Pixel (300,200) -> 0F0, hit=10.
- Overlap and transparency:
  - box1=box2=(50,50), idx1=3, idx2=4; pixel (60,60) -> 00F, hit=01.
  - Then idx1=0 next frame; same pixel -> FF0, hit=10.
- Frame-sync tearing:
  - Change i_color_index1 from 1 to 2 mid-frame -> pixels still F00 until frame_start.
  - Pixel in the frame_start cycle -> F00; next pixel -> 0F0.
- Clipping/wrap: box1_x=1020, BOX_W=64; pixel x=2 -> background (no wrap). Box1_x=600; pixel x=639 -> box colour, x=640 -> background.
- BOX_EDGE_EN: idx1=1, box1=(100,100); pixel (100,110) -> 700; pixel (110,110) -> F00; macro undefined -> both F00.
